// File: rtl/sqrt_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : sqrt_arbiter
// Brief    : Round-robin front end sharing one fixed-latency square-root core
// Revision : 1.0
// =============================================================================
module sqrt_arbiter #(
   parameter int N_REQ    = 4,
   parameter int DATA_W   = 8,
   parameter int SQRT_LAT = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   input  logic                    flush,
   output logic [DATA_W-1:0]       core_data_in,
   input  logic [DATA_W-1:0]       core_data_out,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]       rsp_data,
   output logic                    idle
);

   localparam int C_ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int C_DEPTH = SQRT_LAT + 1;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t             r_state;
   logic [C_ID_W-1:0]  r_rr_ptr;
   logic [C_DEPTH-1:0] r_tag_vld;
   logic [C_ID_W-1:0]  r_tag_id [C_DEPTH];

   logic               w_found;
   logic               w_grant_en;
   logic [C_ID_W-1:0]  w_grant_id;
   logic [C_ID_W-1:0]  w_idx;
   logic [C_ID_W-1:0]  w_next_ptr;
   logic               w_pipe_empty;

   // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
   always_comb begin
      w_found    = 1'b0;
      w_grant_id = r_rr_ptr;
      w_idx      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_idx = C_ID_W'((int'(r_rr_ptr) + k) % N_REQ);
         if (!w_found && req_valid[w_idx]) begin
            w_found    = 1'b1;
            w_grant_id = w_idx;
         end
      end
   end

   assign w_grant_en   = w_found && (r_state == RUN) && !flush && !reset;
   assign req_ready    = w_grant_en ? (N_REQ'(1) << w_grant_id) : '0;
   assign w_next_ptr   = C_ID_W'((int'(w_grant_id) + 1) % N_REQ);
   assign w_pipe_empty = ~|r_tag_vld;
   assign idle         = (r_state == RUN) && w_pipe_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= RUN;
         r_rr_ptr     <= '0;
         r_tag_vld    <= '0;
         rsp_valid    <= '0;
         rsp_data     <= '0;
         core_data_in <= '0;
         for (int i = 0; i < C_DEPTH; i++) begin
            r_tag_id[i] <= '0;
         end
      end else begin
         case (r_state)
            RUN:     if (flush) r_state <= DRAIN;
            DRAIN:   if (w_pipe_empty && !flush) r_state <= RUN;
            default: r_state <= RUN;
         endcase

         if (w_grant_en) begin
            r_rr_ptr     <= w_next_ptr;
            core_data_in <= req_data[w_grant_id*DATA_W +: DATA_W];
         end

         // Tag travels alongside the operand so the last stage lines up with core_data_out.
         r_tag_vld   <= {r_tag_vld[C_DEPTH-2:0], w_grant_en};
         r_tag_id[0] <= w_grant_id;
         for (int i = 1; i < C_DEPTH; i++) begin
            r_tag_id[i] <= r_tag_id[i-1];
         end

         if (r_tag_vld[C_DEPTH-1]) begin
            rsp_valid <= N_REQ'(1) << r_tag_id[C_DEPTH-1];
            rsp_data  <= core_data_out;
         end else begin
            rsp_valid <= '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sqrt_arbiter.sv
`default_nettype none
// Bench for sqrt_arbiter: directed and random stimulus against a transaction-level model
// (pending-response queue with due edges) and a floor-sqrt core with two cycles of latency.
module tb_sqrt_arbiter;

   localparam int N   = 4;
   localparam int W   = 8;
   localparam int LAT = 2;

   logic           clk = 1'b0;
   logic           reset;
   logic           flush;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic [W-1:0]   core_data_in;
   logic [W-1:0]   core_data_out;
   logic [N-1:0]   rsp_valid;
   logic [W-1:0]   rsp_data;
   logic           idle;

   always #5 clk = ~clk;

   sqrt_arbiter #(
      .N_REQ    (N),
      .DATA_W   (W),
      .SQRT_LAT (LAT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .flush         (flush),
      .core_data_in  (core_data_in),
      .core_data_out (core_data_out),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .idle          (idle)
   );

   function automatic logic [W-1:0] isqrt(input logic [W-1:0] x);
      int r;
      r = 0;
      while ((r + 1) * (r + 1) <= int'(x)) r++;
      return W'(r);
   endfunction

   // Core model: floor sqrt, LAT register stages after core_data_in.
   logic [W-1:0] core_pipe [LAT];
   always_ff @(posedge clk) begin
      core_pipe[0] <= isqrt(core_data_in);
      for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
   end
   assign core_data_out = core_pipe[LAT-1];

   typedef struct {
      int owner;
      int value;
      int due;
   } rsp_t;

   rsp_t         pend[$];
   int           m_ptr;
   bit           m_drain;
   int           m_edge;
   logic [W-1:0] m_core_in;
   logic [W-1:0] m_rsp_data;
   logic [N-1:0] m_rsp_valid;
   int           n_tests = 0;
   int           n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int model_grant(input logic [N-1:0] v);
      for (int k = 0; k < N; k++)
         if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_drain = 1'b0; pend.delete();
      m_core_in = '0; m_rsp_valid = '0; m_rsp_data = '0;
   endtask

   // One clock: inputs are already driven (after a negedge); returns at the next negedge.
   task automatic step();
      int           g;
      bit           empty_pre;
      logic [N-1:0] exp_ready;
      rsp_t         r;
      #1;
      g = (reset || m_drain || flush) ? -1 : model_grant(req_valid);
      exp_ready = (g < 0) ? '0 : (N'(1) << g);
      check("req_ready", req_ready, exp_ready);
      check("idle", idle, (!m_drain && pend.size() == 0));
      @(posedge clk);
      m_edge++;
      if (reset) begin
         model_reset();
      end else begin
         empty_pre = (pend.size() == 0);
         if (!m_drain) m_drain = flush;
         else if (empty_pre && !flush) m_drain = 1'b0;
         if (!empty_pre && pend[0].due == m_edge) begin
            m_rsp_valid = N'(1) << pend[0].owner;
            m_rsp_data  = W'(pend[0].value);
            void'(pend.pop_front());
         end else begin
            m_rsp_valid = '0;
         end
         if (g >= 0) begin
            m_ptr     = (g + 1) % N;
            m_core_in = req_data[g*W +: W];
            r.owner   = g;
            r.value   = int'(isqrt(req_data[g*W +: W]));
            r.due     = m_edge + LAT + 1;
            pend.push_back(r);
         end
      end
      #1;
      check("rsp_valid", rsp_valid, m_rsp_valid);
      check("rsp_data", rsp_data, m_rsp_data);
      check("core_data_in", core_data_in, m_core_in);
      @(negedge clk);
   endtask

   task automatic drive(input logic [N-1:0] v, input logic f, input logic rs);
      req_valid = v; flush = f; reset = rs;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wait2;
      m_edge = 0;
      drive('0, 1'b0, 1'b1);
      req_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();
      step();                                   // one checked reset cycle
      drive('0, 1'b0, 1'b0);
      step();

      // Fairness: requesters 0 and 2 always valid, rr_ptr starts at 0.
      req_data = {8'd9, 8'd100, 8'd49, 8'd16};
      drive(4'b0101, 1'b0, 1'b0);
      wait2 = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (req_ready[2]) wait2 = 0; else wait2++;
         check("fair_wait2", (wait2 <= 1), 1);
         step();
      end
      drive('0, 1'b0, 1'b0);
      repeat (4) step();

      // Single request: 144 -> 12.
      req_data = '0;
      req_data[0 +: W] = 8'd144;
      drive(4'b0001, 1'b0, 1'b0);
      step();
      drive('0, 1'b0, 1'b0);
      repeat (3) step();
      check("single_rsp_valid", rsp_valid, 4'b0001);
      check("single_rsp_data", rsp_data, 8'd12);
      step();
      check("single_idle", idle, 1);

      // All four valid with operands 0, 1, 255, 64.
      req_data = {8'd64, 8'd255, 8'd1, 8'd0};
      drive(4'b1111, 1'b0, 1'b0);
      repeat (8) step();
      drive('0, 1'b0, 1'b0);
      repeat (4) step();

      // Flush with three operations in flight.
      drive(4'b1111, 1'b0, 1'b0);
      repeat (3) step();
      drive(4'b1111, 1'b1, 1'b0);
      step();
      drive(4'b1111, 1'b0, 1'b0);
      repeat (8) step();
      drive('0, 1'b0, 1'b0);
      repeat (4) step();

      // Reset with three tags in flight.
      req_data = {8'd200, 8'd81, 8'd25, 8'd4};
      drive(4'b1111, 1'b0, 1'b0);
      repeat (3) step();
      drive('0, 1'b0, 1'b1);
      step();
      drive('0, 1'b0, 1'b0);
      repeat (5) step();
      drive(4'b0110, 1'b0, 1'b0);
      #1;
      check("post_reset_grant", req_ready, 4'b0010);
      step();
      drive('0, 1'b0, 1'b0);
      repeat (4) step();

      // Idle bus.
      repeat (10) step();

      // Randomized traffic with occasional flush and reset.
      for (int c = 0; c < 400; c++) begin
         req_data = {$urandom, $urandom};
         drive(N'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
         step();
      end
      drive('0, 1'b0, 1'b0);
      repeat (6) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
